dac_spi_tx: RTL
===============

Name: dac_spi_tx

Overview:
Downstream consumer of the waveform generators' signed 16-bit sample stream. It accepts one sample per strobe into a single-entry holding register and converts it to offset binary. It prepends a DAC command byte and shifts the 24-bit frame out over a mode-0 SPI link (sclk, mosi, cs_n) to an external DAC. A programmable SCLK divider sets the link rate. Overrun is flagged when the upstream strobe rate exceeds the frame rate.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (legal range 1..255)
DATA_W, 16, sample width
CMD_W, 8, command field width
CMD, 8'h30, command byte sent ahead of each sample (write-and-update)
OFFSET_BIN, 1, 1 = invert sample MSB (two's complement to offset binary); 0 = send raw

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sample_valid  in  1  one-cycle sample strobe (driven by the generator's clk_en-qualified output)
sample_in  in  16  signed sample
sample_ready  out  1  holding register empty
sclk  out  1  SPI clock, idle low
mosi  out  1  SPI data, MSB first
cs_n  out  1  DAC chip select, active-low
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse when cs_n deasserts at end of frame
overrun  out  1  one-cycle pulse when a held, unsent sample is overwritten

Behaviour:
- Reset values: sclk=0, mosi=0, cs_n=1, busy=0, frame_done=0, overrun=0, sample_ready=1. The holding register is cleared, the FSM goes to IDLE, and the divider count is 0.
- Reset mid-frame aborts the frame. cs_n=1 and sclk=0 take effect on the next edge. No frame_done is pulsed.
- Holding register: sample_valid writes sample_in and sets hold_valid. sample_ready = !hold_valid.
- If sample_valid arrives while hold_valid=1 and the hold is not being loaded this cycle, the latest sample wins. The hold is overwritten and overrun pulses for 1 cycle.
- Frame: FRAME_W = CMD_W + DATA_W = 24. The shift register receives {CMD, conv}, where conv = sample ^ 16'h8000 when OFFSET_BIN=1.
- Half-period tick: a counter 0..CLK_DIV-1 produces a tick on terminal count. It restarts at 0 on every state entry.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE -> SETUP when hold_valid=1, on the same edge:
  - the shift register loads;
  - hold_valid clears;
  - cs_n <= 0;
  - mosi <= frame MSB.
- If sample_valid coincides with this load, the new sample enters the hold, hold_valid stays 1, and no overrun is raised.
- SETUP: lasts CLK_DIV cycles with sclk low, then enters SHIFT with sclk <= 1 (first rising edge).
- SHIFT: sclk toggles on every tick, giving FRAME_W rising and FRAME_W falling edges.
  - On each of the first FRAME_W-1 falling edges, mosi takes the next bit.
  - The bit counter counts rising edges.
  - After the FRAME_W-th falling edge the FSM goes to HOLD.
- HOLD: CLK_DIV cycles with sclk=0 and cs_n=0. On exit cs_n <= 1 and frame_done pulses for 1 cycle, then GAP.
- GAP: CLK_DIV cycles with cs_n=1 and mosi=0, then IDLE. Back-to-back frames load on the cycle IDLE is entered if hold_valid=1.
- Frame period from load to IDLE is (2*FRAME_W+3)*CLK_DIV clocks, which is 204 at the defaults.
- mosi is stable for at least CLK_DIV clocks on both sides of every rising sclk edge.
- All outputs are registered; none are combinational from inputs except sample_ready, which is derived from the hold_valid register.

Decomposition:
- Shared package dsp_pkg holds:
  - SAMPLE_W=16;
  - DAC_CMD_WR_UPD=8'h30;
  - the FSM state typedef (IDLE, SETUP, SHIFT, HOLD, GAP);
  - a function to_offset_bin(sample) used by all DAC-facing blocks.
- One sub-module, sclk_half_timer: parameter CLK_DIV, inputs clk, rst and restart, output tick. It is reused by later serial interfaces.

Test Plan:
- Single sample 16'sd32767, CLK_DIV=4 -> bits captured on sclk rising edges are 24'h30FFFF. cs_n is low for exactly 200 clocks. frame_done fires 200 clocks after load, and busy falls 4 clocks later.
- Single sample -16'sd32768 -> frame 24'h300000. With OFFSET_BIN=0 the same sample gives 24'h308000.
- Strobe every 204 clocks with alternating +32767 / -32768 -> frames are contiguous, GAP is exactly 4 clocks with cs_n high, and overrun never asserts.
- Three strobes (values 1, 2, 3) at cycles 0, 10 and 20 -> frame1 carries 1. overrun pulses once, at cycle 20. frame2 carries 3 (conv 16'h8003, frame 24'h308003).
- Assert rst at cycle 100 of a frame -> cs_n=1, sclk=0 and mosi=0 on the next edge. No frame_done, sample_ready=1. A fresh sample afterwards produces a complete, correct frame.
- CLK_DIV=1, sample 16'h1234 -> sclk toggles every clock, frame 24'h309234, period 51 clocks.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the DAC-facing blocks of the waveform datapath:
// sample width, DAC command codes, link FSM states and the sample format conversion.
package dsp_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic [7:0] DAC_CMD_WR_UPD = 8'h30;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } dac_state_t;

    // Two's complement to offset binary: flipping the sign bit maps -FS..+FS onto 0..2*FS.
    function automatic logic [SAMPLE_W-1:0] to_offset_bin(input logic signed [SAMPLE_W-1:0] sample);
        return sample ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/sclk_half_timer.sv
// Free-running half-period timer for serial links: ticks once every CLK_DIV clocks,
// and the count can be forced back to zero so each phase starts with a full interval.
module sclk_half_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Single-sample buffered SPI (mode 0) transmitter for an external DAC: each frame is
// the command byte followed by the converted sample, MSB first.
module dac_spi_tx
    import dsp_pkg::*;
#(
    parameter int               CLK_DIV    = 4,
    parameter int               DATA_W     = SAMPLE_W,
    parameter int               CMD_W      = 8,
    parameter logic [CMD_W-1:0] CMD        = DAC_CMD_WR_UPD,
    parameter bit               OFFSET_BIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              sample_ready,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int BCNT_W  = $clog2(FRAME_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_W);

    dac_state_t         state, state_next;
    logic [DATA_W-1:0]  hold;
    logic               hold_valid;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] shreg;
    logic [BCNT_W-1:0]  bit_cnt;
    logic               tick;
    logic               load;
    logic               restart;

    sclk_half_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign frame        = {CMD, OFFSET_BIN ? to_offset_bin(hold) : hold};
    assign sample_ready = !hold_valid;

    // A frame loads either from IDLE or straight out of GAP so back-to-back frames stay contiguous.
    assign load    = (state_next == SETUP) && (state != SETUP);
    assign restart = (state_next != state);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hold_valid) state_next = SETUP;
            SETUP:   if (tick) state_next = SHIFT;
            SHIFT:   if (tick && !sclk && bit_cnt == LAST_BIT) state_next = HOLD;
            HOLD:    if (tick) state_next = GAP;
            GAP:     if (tick) state_next = hold_valid ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latest sample wins; a load on the same edge frees the slot, so that case is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= sample_valid && hold_valid && !load;
            if (sample_valid) begin
                hold       <= sample_in;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            busy       <= (state_next != IDLE);
            frame_done <= 1'b0;
            if (load) begin
                shreg   <= frame;
                mosi    <= frame[FRAME_W-1];
                cs_n    <= 1'b0;
                sclk    <= 1'b0;
                bit_cnt <= '0;
            end else if (tick) begin
                case (state)
                    SETUP: begin
                        sclk    <= 1'b1;
                        bit_cnt <= BCNT_W'(1);
                    end
                    // Data advances on falling edges only, so it is settled a full half-period around each rise.
                    SHIFT: begin
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (bit_cnt != LAST_BIT) begin
                                shreg <= shreg << 1;
                                mosi  <= shreg[FRAME_W-2];
                            end
                        end else if (bit_cnt != LAST_BIT) begin
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        cs_n       <= 1'b1;
                        frame_done <= 1'b1;
                        mosi       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
